transaction_rr_arbiter: RTL and testbench
=========================================

// Module: transaction_rr_arbiter
// PURPOSE
//  Round-robin arbiter between the 4 input FIFOs and the 4 output FIFOs of the transaction layer.
//  - Pops the head word of one non-empty input FIFO per cycle.
//  - Routes the word to the output FIFO selected by its destination field, word[W-1:W-2].
//  - Stalls all traffic while any output FIFO reports almost_full or full.
//  - arb_enable comes from the layer's main FSM, which asserts it in its active state.
// PARAMETERS
//  FIFO_WORD_SIZE  10  word width W; dest = word[W-1:W-2], payload = word[W-3:0]; W >= 3
//  NUM_PORTS       4   number of input and output FIFOs; fixed at 4 (2-bit dest field)
// PORTS
//  clk                   in   1  single clock; all state updates on posedge
//  reset                 in   1  synchronous, active-high reset
//  arb_enable            in   1  1 = arbitration allowed
//  fifo_in_empty         in   4  empty flag of input FIFO i
//  fifo_in_data0..3      in   W  head word of input FIFO i (first-word fall-through); valid when !empty[i]
//  fifo_out_almost_full  in   4  almost_full flag of output FIFO j
//  fifo_out_full         in   4  full flag of output FIFO j
//  pop_in                out  4  one-hot pop to input FIFOs; combinational
//  push_out              out  4  one-hot push to output FIFOs; registered
//  data_out              out  W  word for the output FIFOs; registered
//  arb_state             out  2  FSM state: 0 IDLE, 1 ARB, 2 STALL
//  grant_idx             out  2  index of the last granted input; registered
// BEHAVIOUR
//  Reset values (reset=1 at a posedge)
//   - arb_state=IDLE, push_out=0, data_out=0, grant_idx=0.
//   - rr_ptr=3, so the first grant after reset goes to port 0.
//   - pop_in is forced to 0 combinationally whenever reset=1.
//  Definitions
//   - stall  = |fifo_out_almost_full | |fifo_out_full
//   - any_rq = |(~fifo_in_empty)
//  FSM (registered), next state evaluated every cycle:
//   - if !arb_enable or !any_rq -> IDLE
//   - else if stall -> STALL
//   - else -> ARB
//   - So the first pop happens one cycle after the inputs that allow it become true.
//  Grant condition (combinational)
//   - gnt_ok = (arb_state==ARB) & arb_enable & !stall & any_rq & !reset
//   - Search order: rr_ptr+1, +2, +3, +0, mod 4 with wrap-around.
//   - The first non-empty input g wins; pop_in = onehot(g) in that same cycle.
//  At the edge that ends a granted cycle
//   - data_out <= fifo_in_data_g
//   - push_out <= onehot(fifo_in_data_g[W-1:W-2])
//   - grant_idx <= g, rr_ptr <= g
//  If there is no grant: push_out <= 0; data_out, grant_idx and rr_ptr hold.
//  Latency and throughput
//   - A word popped in cycle N is pushed in cycle N+1 (1-cycle latency).
//   - Peak throughput is 1 word per cycle.
//  Stall
//   - No new pops; the single in-flight word still pushes.
//   - almost_full thresholds must leave >= 2 free slots, so full is never overrun.
//   - Resume uses priority order rr_ptr+1 (rotation continues, no restart).
//  arb_enable falling mid-stream: pop_in gated the same cycle; the in-flight push completes.
//  Only one requester: it is granted every cycle; rr_ptr stays at that port.
//  Reset mid-stream: push_out clears at that edge; the in-flight word is dropped (system-wide reset).
//  Several words to the same output in consecutive cycles are legal; push_out repeats one-hot.
// TESTING
//  1. FIFO0 head 10'h0A6, enable -> state ARB, then pop_in=0001; next cycle push_out=0001, data_out=0A6.
//  2. Heads 0A6/145/278/389 on ports 0-3, one word each -> grants 0,1,2,3 on consecutive cycles;
//     push_out=0001,0010,0100,1000; then state IDLE.
//  3. Traffic pending, almost_full[0]=1 -> next cycle arb_state=STALL, pop_in=0, one in-flight push only;
//     drop the flag -> ARB, resumes at rr_ptr+1.
//  4. Only FIFO2 holds 3 words with dest 3 -> pop_in=0100 for 3 cycles, push_out=1000 x3, grant_idx=2.
//  5. Reset asserted while streaming -> pop_in=0 in that cycle, push_out=0 after the edge, state IDLE;
//     first grant after release goes to port 0 when all ports request.
//  6. arb_enable=0 with all FIFOs non-empty -> pop_in=0, push_out=0 and arb_state=IDLE indefinitely.

Source files
------------

// File: rtl/transaction_rr_arbiter.sv
// Round-robin arbiter moving one word per cycle from four first-word-fall-through
// input FIFOs to the output FIFO named by each word's 2-bit destination field.
module transaction_rr_arbiter #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int NUM_PORTS      = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_arb_enable,
  input  logic [NUM_PORTS-1:0]      i_fifo_in_empty,
  input  logic [FIFO_WORD_SIZE-1:0] i_fifo_in_data0,
  input  logic [FIFO_WORD_SIZE-1:0] i_fifo_in_data1,
  input  logic [FIFO_WORD_SIZE-1:0] i_fifo_in_data2,
  input  logic [FIFO_WORD_SIZE-1:0] i_fifo_in_data3,
  input  logic [NUM_PORTS-1:0]      i_fifo_out_almost_full,
  input  logic [NUM_PORTS-1:0]      i_fifo_out_full,
  output logic [NUM_PORTS-1:0]      o_pop_in,
  output logic [NUM_PORTS-1:0]      o_push_out,
  output logic [FIFO_WORD_SIZE-1:0] o_data_out,
  output logic [1:0]                o_arb_state,
  output logic [1:0]                o_grant_idx
);

  localparam int W = FIFO_WORD_SIZE;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   r_rr_ptr;
  logic [1:0]   r_grant_idx;
  logic [3:0]   r_push_out;
  logic [W-1:0] r_data_out;

  logic [W-1:0] w_in_data [4];
  logic [1:0]   w_cand [4];
  logic [3:0]   w_cand_rq;
  logic [1:0]   w_gnt_idx;
  logic [W-1:0] w_gnt_word;
  logic         w_stall;
  logic         w_any_rq;
  logic         w_gnt_ok;
  logic [1:0]   w_state_next;

  assign w_in_data[0] = i_fifo_in_data0;
  assign w_in_data[1] = i_fifo_in_data1;
  assign w_in_data[2] = i_fifo_in_data2;
  assign w_in_data[3] = i_fifo_in_data3;

  assign w_stall  = (|i_fifo_out_almost_full) | (|i_fifo_out_full);
  assign w_any_rq = |(~i_fifo_in_empty);
  assign w_gnt_ok = (r_state == S_ARB) & i_arb_enable & ~w_stall & w_any_rq & ~i_reset;

  // Candidate k is the port k+1 places after the last grant, so candidate 0 has top priority.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign w_cand[gi]    = r_rr_ptr + 2'(gi + 1);
      assign w_cand_rq[gi] = ~i_fifo_in_empty[w_cand[gi]];
    end
  endgenerate

  always_comb begin
    w_gnt_idx = w_cand[0];
    for (int k = 3; k >= 0; k--) begin
      if (w_cand_rq[k]) begin
        w_gnt_idx = w_cand[k];
      end
    end
  end

  assign w_gnt_word = w_in_data[w_gnt_idx];
  assign o_pop_in   = w_gnt_ok ? (4'b0001 << w_gnt_idx) : 4'b0000;

  always_comb begin
    w_state_next = S_ARB;
    if (!i_arb_enable || !w_any_rq) begin
      w_state_next = S_IDLE;
    end else if (w_stall) begin
      w_state_next = S_STALL;
    end
  end

  // Pointer reset to 3 so that port 0 is first in line after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 2'd3;
      r_grant_idx <= 2'd0;
      r_push_out  <= 4'b0000;
      r_data_out  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_gnt_ok) begin
        r_data_out  <= w_gnt_word;
        r_push_out  <= 4'b0001 << w_gnt_word[W-1:W-2];
        r_grant_idx <= w_gnt_idx;
        r_rr_ptr    <= w_gnt_idx;
      end else begin
        r_push_out <= 4'b0000;
      end
    end
  end

  assign o_push_out  = r_push_out;
  assign o_data_out  = r_data_out;
  assign o_arb_state = r_state;
  assign o_grant_idx = r_grant_idx;

endmodule

// File: tb/tb_transaction_rr_arbiter.sv
// Self-checking bench: input FIFOs are modelled as queues, and a cycle-level
// reference model predicts state, pops and pushes from the arbitration rules.
module tb_transaction_rr_arbiter;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   empty;
  logic [3:0]   af;
  logic [3:0]   full;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   o_pop_in;
  logic [3:0]   o_push_out;
  logic [W-1:0] o_data_out;
  logic [1:0]   o_arb_state;
  logic [1:0]   o_grant_idx;

  always #5 clk = ~clk;

  transaction_rr_arbiter #(.FIFO_WORD_SIZE(W), .NUM_PORTS(4)) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_arb_enable           (en),
    .i_fifo_in_empty        (empty),
    .i_fifo_in_data0        (d0),
    .i_fifo_in_data1        (d1),
    .i_fifo_in_data2        (d2),
    .i_fifo_in_data3        (d3),
    .i_fifo_out_almost_full (af),
    .i_fifo_out_full        (full),
    .o_pop_in               (o_pop_in),
    .o_push_out             (o_push_out),
    .o_data_out             (o_data_out),
    .o_arb_state            (o_arb_state),
    .o_grant_idx            (o_grant_idx)
  );

  logic [W-1:0] in_q [4][$];

  int           m_state, m_gidx, m_ptr, m_g;
  logic [3:0]   m_push, m_pop;
  logic [W-1:0] m_data;
  bit           m_any, m_stall;
  int           checks = 0;
  int           errors = 0;
  logic [3:0]   pop_log[$];
  logic [3:0]   push_log[$];

  // Drive FIFO heads/flags at the falling edge, predict this cycle's grant, settle.
  task automatic drive_eval();
    logic [W-1:0] dv [4];
    m_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      empty[i] = (in_q[i].size() == 0);
      dv[i]    = empty[i] ? W'($urandom) : in_q[i][0];
      if (!empty[i]) m_any = 1'b1;
    end
    d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
    m_stall = (af != 4'b0) || (full != 4'b0);
    m_g = -1;
    if (m_state == 1 && en && !m_stall && m_any && !rst) begin
      for (int k = 1; k <= 4; k++) begin
        int p;
        p = (m_ptr + k) % 4;
        if (m_g < 0 && in_q[p].size() > 0) m_g = p;
      end
    end
    m_pop = (m_g >= 0) ? 4'(1 << m_g) : 4'b0000;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_push = 4'b0; m_data = '0; m_gidx = 0; m_ptr = 3;
    end else begin
      m_state = (!en || !m_any) ? 0 : (m_stall ? 2 : 1);
      if (m_g >= 0) begin
        m_data = in_q[m_g].pop_front();
        m_push = 4'(1 << m_data[W-1:W-2]);
        m_gidx = m_g;
        m_ptr  = m_g;
        $display("txn: in %0d -> out %0d word %h", m_g, m_data[W-1:W-2], m_data);
      end else begin
        m_push = 4'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) in_q[i].delete();
    rst = 1'b1; en = 1'b0; af = 4'b0; full = 4'b0;
    drive_eval();
    advance();
    rst = 1'b0;
    pop_log.delete();
    push_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; af = 4'b0; full = 4'b0;
    for (int i = 0; i < 4; i++) in_q[i].push_back(W'($urandom));
    drive_eval();
    checks++;
    if (o_pop_in !== 4'b0) begin
      errors++; $display("FAIL reset_pop: got %b expected 0000", o_pop_in);
    end
    advance();
    drive_eval();
    checks++;
    if ({o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in} !== {2'b00, 2'b00, 4'b0, 10'h000, 4'b0}) begin
      errors++;
      $display("FAIL reset_values: state/gidx/push/data/pop got %0d/%0d/%b/%h/%b expected 0/0/0000/000/0000",
               o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in);
    end
    advance();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) in_q[i].delete();
  endtask

  task automatic test_single_word();
    en = 1'b1;
    in_q[0].push_back(10'h0A6);
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive_eval();
      checks++;
      if ({o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in} !== {2'(m_state), 2'(m_gidx), m_push, m_data, m_pop}) begin
        errors++;
        $display("FAIL single_word cyc %0d: state/gidx/push/data/pop got %0d/%0d/%b/%h/%b expected %0d/%0d/%b/%h/%b",
                 cyc, o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in, m_state, m_gidx, m_push, m_data, m_pop);
      end
      if (cyc == 1) begin
        checks++;
        if (o_pop_in !== 4'b0001 || o_arb_state !== 2'd1) begin
          errors++; $display("FAIL single_word_pop: pop/state got %b/%0d expected 0001/1", o_pop_in, o_arb_state);
        end
      end
      if (cyc == 2) begin
        checks++;
        if (o_push_out !== 4'b0001 || o_data_out !== 10'h0A6) begin
          errors++; $display("FAIL single_word_push: push/data got %b/%h expected 0001/0a6", o_push_out, o_data_out);
        end
      end
      advance();
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_oh [4];
    do_reset();
    en = 1'b1;
    in_q[0].push_back(10'h0A6); in_q[1].push_back(10'h145);
    in_q[2].push_back(10'h278); in_q[3].push_back(10'h389);
    exp_oh[0] = 4'b0001; exp_oh[1] = 4'b0010; exp_oh[2] = 4'b0100; exp_oh[3] = 4'b1000;
    for (int cyc = 0; cyc < 7; cyc++) begin
      drive_eval();
      checks++;
      if ({o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in} !== {2'(m_state), 2'(m_gidx), m_push, m_data, m_pop}) begin
        errors++;
        $display("FAIL rotation cyc %0d: state/gidx/push/data/pop got %0d/%0d/%b/%h/%b expected %0d/%0d/%b/%h/%b",
                 cyc, o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in, m_state, m_gidx, m_push, m_data, m_pop);
      end
      if (o_pop_in != 4'b0) pop_log.push_back(o_pop_in);
      if (o_push_out != 4'b0) push_log.push_back(o_push_out);
      if (cyc == 6) begin
        checks++;
        if (o_arb_state !== 2'd0) begin
          errors++; $display("FAIL rotation_idle: state got %0d expected 0", o_arb_state);
        end
      end
      advance();
    end
    checks++;
    if (pop_log.size() != 4 || push_log.size() != 4) begin
      errors++; $display("FAIL rotation_count: pops/pushes got %0d/%0d expected 4/4", pop_log.size(), push_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pop_log[i] !== exp_oh[i] || push_log[i] !== exp_oh[i]) begin
          errors++; $display("FAIL rotation_order %0d: pop/push got %b/%b expected %b", i, pop_log[i], push_log[i], exp_oh[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int stall_pushes;
    do_reset();
    en = 1'b1;
    stall_pushes = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) in_q[i].push_back(W'($urandom));
    for (int cyc = 0; cyc < 24; cyc++) begin
      af = (cyc >= 3 && cyc <= 6) ? 4'b0001 : 4'b0000;
      drive_eval();
      checks++;
      if ({o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in} !== {2'(m_state), 2'(m_gidx), m_push, m_data, m_pop}) begin
        errors++;
        $display("FAIL stall cyc %0d: state/gidx/push/data/pop got %0d/%0d/%b/%h/%b expected %0d/%0d/%b/%h/%b",
                 cyc, o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in, m_state, m_gidx, m_push, m_data, m_pop);
      end
      if (cyc == 3) begin
        checks++;
        if (o_pop_in !== 4'b0 || o_push_out === 4'b0) begin
          errors++; $display("FAIL stall_inflight: pop/push got %b/%b expected 0000/nonzero", o_pop_in, o_push_out);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (o_arb_state !== 2'd2 || o_pop_in !== 4'b0) begin
          errors++; $display("FAIL stall_state: state/pop got %0d/%b expected 2/0000", o_arb_state, o_pop_in);
        end
      end
      if (cyc >= 4 && cyc <= 7 && o_push_out != 4'b0) stall_pushes++;
      if (cyc == 8) begin
        checks++;
        if (o_arb_state !== 2'd1 || o_pop_in !== 4'b0100) begin
          errors++; $display("FAIL stall_resume: state/pop got %0d/%b expected 1/0100", o_arb_state, o_pop_in);
        end
      end
      advance();
    end
    checks++;
    if (stall_pushes != 0) begin
      errors++; $display("FAIL stall_pushes: got %0d expected 0", stall_pushes);
    end
  endtask

  task automatic test_single_requester();
    int n_pop, n_push;
    do_reset();
    en = 1'b1;
    n_pop = 0; n_push = 0;
    for (int j = 0; j < 3; j++) in_q[2].push_back({2'b11, 8'($urandom)});
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive_eval();
      checks++;
      if ({o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in} !== {2'(m_state), 2'(m_gidx), m_push, m_data, m_pop}) begin
        errors++;
        $display("FAIL single_req cyc %0d: state/gidx/push/data/pop got %0d/%0d/%b/%h/%b expected %0d/%0d/%b/%h/%b",
                 cyc, o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in, m_state, m_gidx, m_push, m_data, m_pop);
      end
      if (o_pop_in == 4'b0100) n_pop++;
      if (o_push_out == 4'b1000) n_push++;
      advance();
    end
    checks++;
    if (n_pop != 3 || n_push != 3 || o_grant_idx !== 2'd2) begin
      errors++; $display("FAIL single_req_totals: pops/pushes/gidx got %0d/%0d/%0d expected 3/3/2", n_pop, n_push, o_grant_idx);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) in_q[i].push_back(W'($urandom));
    for (int cyc = 0; cyc < 20; cyc++) begin
      rst = (cyc == 4);
      drive_eval();
      checks++;
      if ({o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in} !== {2'(m_state), 2'(m_gidx), m_push, m_data, m_pop}) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: state/gidx/push/data/pop got %0d/%0d/%b/%h/%b expected %0d/%0d/%b/%h/%b",
                 cyc, o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in, m_state, m_gidx, m_push, m_data, m_pop);
      end
      if (cyc == 4) begin
        checks++;
        if (o_pop_in !== 4'b0) begin
          errors++; $display("FAIL reset_mid_pop: got %b expected 0000", o_pop_in);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (o_push_out !== 4'b0 || o_arb_state !== 2'd0) begin
          errors++; $display("FAIL reset_mid_clear: push/state got %b/%0d expected 0000/0", o_push_out, o_arb_state);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (o_pop_in !== 4'b0001) begin
          errors++; $display("FAIL reset_mid_first: pop got %b expected 0001", o_pop_in);
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_disable();
    int n_act;
    do_reset();
    en = 1'b0;
    n_act = 0;
    for (int i = 0; i < 4; i++) in_q[i].push_back(W'($urandom));
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive_eval();
      checks++;
      if ({o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in} !== {2'(m_state), 2'(m_gidx), m_push, m_data, m_pop}) begin
        errors++;
        $display("FAIL disable cyc %0d: state/gidx/push/data/pop got %0d/%0d/%b/%h/%b expected %0d/%0d/%b/%h/%b",
                 cyc, o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in, m_state, m_gidx, m_push, m_data, m_pop);
      end
      if (o_pop_in != 4'b0 || o_push_out != 4'b0 || o_arb_state != 2'd0) n_act++;
      advance();
    end
    checks++;
    if (n_act != 0) begin
      errors++; $display("FAIL disable_quiet: active cycles got %0d expected 0", n_act);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++)
        if (in_q[i].size() < 2 && $urandom_range(0, 2) == 0)
          for (int j = 0; j < $urandom_range(1, 3); j++) in_q[i].push_back(W'($urandom));
      en   = ($urandom_range(0, 7) != 0);
      af   = ($urandom_range(0, 5) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      full = ($urandom_range(0, 19) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      rst  = ($urandom_range(0, 99) == 0);
      drive_eval();
      checks++;
      if ({o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in} !== {2'(m_state), 2'(m_gidx), m_push, m_data, m_pop}) begin
        errors++;
        $display("FAIL random cyc %0d: state/gidx/push/data/pop got %0d/%0d/%b/%h/%b expected %0d/%0d/%b/%h/%b",
                 cyc, o_arb_state, o_grant_idx, o_push_out, o_data_out, o_pop_in, m_state, m_gidx, m_push, m_data, m_pop);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; af = 4'b0; full = 4'b0;
    empty = 4'hF; d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    m_state = 0; m_gidx = 0; m_ptr = 3; m_g = -1;
    m_push = 4'b0; m_pop = 4'b0; m_data = '0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_rotation();
    test_stall();
    test_single_requester();
    test_reset_mid();
    test_disable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
